// File: rtl/i2d_imem.sv
// i2d_imem: Wishbone slave instruction/data memory with background NOP clear and fixed wait states.
// Writes are enabled only when I2D_IMEM_WRITE_EN is defined; otherwise write requests end in an error.
`ifndef I2D_INS_NOP
`define I2D_INS_NOP 6'h15
`endif
module i2d_imem #(
  parameter int AW = 10,
  parameter int WAIT = 1,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o
);
  localparam logic [31:0] NOP = {`I2D_INS_NOP, 26'b0};
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_n;
  logic [31:0] mem [2**AW];
  logic [AW-1:0] ic, idx_q, cur_idx;
  logic init_done;
  logic [3:0] wcnt, sel_q, cur_sel;
  logic we_q, cur_we;
  logic [31:0] dat_q, cur_dat, rd_word, wr_word;
  logic req, in_win, aligned, wr_ok, idle_rty, idle_err, idle_go;
  logic ack_n, err_n, rty_n;
  assign req = cyc_i & stb_i;
  assign in_win = adr_i[31:AW+2] == BASE[31:AW+2];
  assign aligned = adr_i[1:0] == 2'b00;
`ifdef I2D_IMEM_WRITE_EN
  assign wr_ok = 1'b1;
`else
  assign wr_ok = !we_i;
`endif
  assign idle_rty = req & !init_done;
  assign idle_err = req & init_done & (!in_win | !aligned | !wr_ok);
  assign idle_go = req & init_done & in_win & aligned & wr_ok;
  // In IDLE the live bus fields are used so that WAIT=0 can respond on the accepting edge
  assign cur_idx = state == S_IDLE ? adr_i[AW+1:2] : idx_q;
  assign cur_we = state == S_IDLE ? we_i : we_q;
  assign cur_sel = state == S_IDLE ? sel_i : sel_q;
  assign cur_dat = state == S_IDLE ? dat_i : dat_q;
  assign rd_word = mem[cur_idx];
  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < 4; b++)
      wr_word[8*b+:8] = cur_sel[b] ? cur_dat[8*b+:8] : rd_word[8*b+:8];
  end
  always_ff @(posedge clk)
    state <= !rst ? S_IDLE : state_n;
  always_comb begin
    state_n = state == S_IDLE ? ((idle_rty | idle_err | (idle_go && WAIT == 0)) ? S_RESP : idle_go ? S_WAIT : S_IDLE)
            : state == S_WAIT ? (!req ? S_IDLE : wcnt == 4'd1 ? S_RESP : S_WAIT)
            : S_IDLE;
  end
  always_comb begin
    ack_n = state == S_IDLE ? (idle_go && WAIT == 0) : (state == S_WAIT && req && wcnt == 4'd1);
    err_n = state == S_IDLE && idle_err;
    rty_n = state == S_IDLE && idle_rty;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rty_o <= 1'b0;
      dat_o <= 32'b0;
      wcnt <= 4'd0;
      ic <= '0;
      init_done <= 1'b0;
      idx_q <= '0;
      we_q <= 1'b0;
      sel_q <= 4'b0;
      dat_q <= 32'b0;
    end else begin
      ack_o <= ack_n;
      err_o <= err_n;
      rty_o <= rty_n;
      dat_o <= ack_n ? (cur_we ? wr_word : rd_word) : dat_o;
      if (!init_done) begin
        ic <= ic + 1'b1;
        init_done <= ic == '1;
      end
      if (state == S_IDLE && idle_go) begin
        idx_q <= adr_i[AW+1:2];
        we_q <= we_i;
        sel_q <= sel_i;
        dat_q <= dat_i;
        wcnt <= 4'(WAIT);
      end else if (state == S_WAIT && req)
        wcnt <= wcnt - 4'd1;
    end
  always_ff @(posedge clk)
    if (rst && !init_done) mem[ic] <= NOP;
`ifdef I2D_IMEM_WRITE_EN
    else if (rst && ack_n && cur_we) mem[cur_idx] <= wr_word;
`endif
endmodule

// File: tb/tb_i2d_imem.sv
// tb_i2d_imem: scoreboard bench for i2d_imem (AW=4, WAIT=2, BASE=0), directed vectors.
`ifndef I2D_INS_NOP
`define I2D_INS_NOP 6'h15
`endif
module tb_i2d_imem;
  localparam int WT = 2;
  localparam logic [31:0] NOP = {`I2D_INS_NOP, 26'b0};
  localparam logic [1:0] K_ACK = 2'd0, K_ERR = 2'd1, K_RTY = 2'd2;
  typedef struct packed {logic [1:0] k; logic [31:0] d; logic [31:0] e;} exp_t;
  logic clk = 0, rst = 0, cyc = 0, stb = 0, we = 0;
  logic [31:0] adr = 0, dat = 0, dat_o;
  logic [3:0] sel = 0;
  logic ack, err, rty, prev_ack = 0;
  int cnt = 0, nresp = 0, checks = 0, passes = 0;
  logic [31:0] last = 0;
  exp_t q[$];
  i2d_imem #(.AW(4), .WAIT(WT), .BASE(32'h0)) dut (
    .clk(clk), .rst(rst), .adr_i(adr), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .sel_i(sel), .dat_i(dat), .dat_o(dat_o), .ack_o(ack), .err_o(err), .rty_o(rty)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  always @(negedge clk) begin
    exp_t it;
    if (ack | err | rty) begin
      nresp++;
      chk("onehot", 32'(ack) + 32'(err) + 32'(rty), 32'd1);
      if (q.size() == 0) chk("unexpected_resp", 32'(nresp), 32'd0);
      else begin
        it = q.pop_front();
        chk("resp_kind", {30'b0, err, rty}, (it.k == K_ERR) ? 32'd2 : (it.k == K_RTY) ? 32'd1 : 32'd0);
        chk("resp_data", dat_o, it.d);
        chk("resp_edge", 32'(cnt), it.e);
      end
    end
    if (ack) chk("ack_not_adjacent", 32'(prev_ack), 32'd0);
    prev_ack = ack;
  end
  task automatic push(input logic [1:0] k, input logic [31:0] d, input int e);
    if (k == K_ACK) last = d;
    q.push_back(exp_t'{k, last, 32'(e + (k == K_ACK ? WT : 0))});
  endtask
  task automatic wait_resp(input int n0, input int n);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (nresp >= n0 + n) return;
    end
    chk("resp_timeout", 32'(nresp - n0), 32'(n));
  endtask
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                      input logic [1:0] k, input logic [31:0] ed);
    int n0;
    @(posedge clk); #1;
    adr = a; we = w; sel = s; dat = d; cyc = 1; stb = 1;
    n0 = nresp;
    push(k, ed, cnt + 1);
    wait_resp(n0, 1);
    cyc = 0; stb = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n0, e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dat", dat_o, 32'h0);
    chk("reset_resp", {29'b0, ack, err, rty}, 32'h0);
    @(posedge clk); #1 rst = 1;
    xfer(32'h0, 0, 4'hF, 0, K_RTY, 0);
    repeat (20) @(posedge clk);
    xfer(32'h8, 0, 4'hF, 0, K_ACK, NOP);
`ifdef I2D_IMEM_WRITE_EN
    xfer(32'h4, 1, 4'b1111, 32'hDEADBEEF, K_ACK, 32'hDEADBEEF);
    xfer(32'h4, 1, 4'b0001, 32'h000000AA, K_ACK, 32'hDEADBEAA);
    xfer(32'h4, 0, 4'hF, 0, K_ACK, 32'hDEADBEAA);
`else
    xfer(32'h4, 1, 4'b1111, 32'hDEADBEEF, K_ERR, 0);
    xfer(32'h4, 1, 4'b0001, 32'h000000AA, K_ERR, 0);
    xfer(32'h4, 0, 4'hF, 0, K_ACK, NOP);
`endif
    xfer(32'h40, 0, 4'hF, 0, K_ERR, 0);
    xfer(32'h6, 0, 4'hF, 0, K_ERR, 0);
    @(posedge clk); #1;
`ifdef I2D_IMEM_WRITE_EN
    adr = 32'h8; we = 1; sel = 4'hF; dat = 32'h12345678; cyc = 1; stb = 1;
`else
    adr = 32'h8; we = 0; sel = 4'hF; dat = 32'h12345678; cyc = 1; stb = 1;
`endif
    n0 = nresp;
    @(posedge clk);
    @(posedge clk); #1 cyc = 0; stb = 0;
    repeat (6) @(negedge clk);
    chk("abort_no_resp", 32'(nresp), 32'(n0));
    xfer(32'h8, 0, 4'hF, 0, K_ACK, NOP);
    @(posedge clk); #1;
    adr = 32'h8; we = 0; sel = 4'hF; cyc = 1; stb = 1;
    e = cnt + 1;
    n0 = nresp;
    push(K_ACK, NOP, e);
    push(K_ACK, NOP, e + WT + 2);
    push(K_ACK, NOP, e + 2 * (WT + 2));
    wait_resp(n0, 3);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    adr = 32'h8; cyc = 1; stb = 1;
    @(posedge clk); #1;
    rst = 0; cyc = 0; stb = 0;
    n0 = nresp;
    @(posedge clk); #1 rst = 1;
    last = 0;
    repeat (4) @(negedge clk);
    chk("reset_midwait_no_resp", 32'(nresp), 32'(n0));
    chk("reset_midwait_dat", dat_o, 32'h0);
    xfer(32'h0, 0, 4'hF, 0, K_RTY, 0);
    repeat (20) @(posedge clk);
`ifdef I2D_IMEM_WRITE_EN
    xfer(32'hC, 1, 4'hF, 32'hFFFFFFFF, K_ACK, 32'hFFFFFFFF);
    xfer(32'hC, 0, 4'hF, 0, K_ACK, 32'hFFFFFFFF);
`else
    xfer(32'hC, 1, 4'hF, 32'hFFFFFFFF, K_ERR, 0);
    xfer(32'hC, 0, 4'hF, 0, K_ACK, NOP);
`endif
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/i2d_imem.md
# i2d_imem

Wishbone slave instruction/data memory for the i2d core: the responder end of the fetch unit's Wishbone read interface. It decodes the address against a base window and returns one word per transfer after a fixed number of wait states, terminating each transfer with a one-cycle `ack_o`, `err_o` or `rty_o`. After reset it clears its array to NOP words in the background and answers with retry until the clear completes.

## Interface
- `AW`, 10: word-address bits; the array holds 2^AW 32-bit words.
- `WAIT`, 1: wait states inserted between request acceptance and the response cycle (0..15).
- `BASE`, 32'h0000_0000: window base; must be aligned to 2^(AW+2).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `adr_i`  in  32  byte address.
- `cyc_i`  in  1  bus cycle active.
- `stb_i`  in  1  strobe.
- `we_i`  in  1  1 = write.
- `sel_i`  in  4  byte enables; bit 3 selects dat[31:24].
- `dat_i`  in  32  write data.
- `dat_o`  out  32  read data; valid while `ack_o`=1.
- `ack_o`  out  1  normal termination, one-cycle pulse.
- `err_o`  out  1  error termination, one-cycle pulse.
- `rty_o`  out  1  retry termination, one-cycle pulse.

## Operation
- **Request:** `req = cyc_i & stb_i`. A request is sampled only in IDLE.
- **Init counter:** `ic` runs 0..2^AW-1 after reset. It writes `{`I2D_INS_NOP, 26'b0}` to word `ic` each cycle, then sets `init_done`. It runs independently of the FSM.
- **FSM states:** INIT-free design; the states are IDLE, WAIT, RESP. Exactly one of ack/err/rty is high during RESP, and none is high outside RESP.
- **IDLE, `req` sampled at an edge:**
  - if `!init_done` → RESP with `rty_o`.
  - else if `adr_i[31:AW+2] != BASE[31:AW+2]` or `adr_i[1:0] != 0` → RESP with `err_o`.
  - else → latch the word index `adr_i[AW+1:2]`, `we_i`, `sel_i` and `dat_i`; load `wcnt = WAIT`; go to WAIT (or directly to RESP with ack if WAIT=0).
- **WAIT:**
  - if `req` is low at an edge → abort to IDLE: no response, no write.
  - else decrement `wcnt`; on reaching 0 → RESP with `ack_o`.
- **RESP:** lasts one cycle, then IDLE unconditionally. `req` is not sampled in RESP, so a held strobe is never answered twice.
- **Read:** `dat_o` is loaded from the latched word on entry to RESP with ack. It holds its previous value on err/rty and when idle.
- **Write:** performed on the edge entering RESP with ack, per byte lane from `sel_i`. `dat_o` then returns the post-write word.
- **Reset:** at any edge with `rst`=0:
  - outputs go to 0 (`dat_o`=0, `ack_o`=`err_o`=`rty_o`=0).
  - FSM goes to IDLE, `ic`=0, `init_done`=0.
  - any pending transfer is dropped; the clear restarts.

## Timing
- **Ack latency:** `req` sampled in IDLE at edge k gives ack during cycle k+WAIT+1.
- **Throughput:** at most one transfer per WAIT+2 cycles; two consecutive cycles never both carry ack.
- **err/rty latency:** high during the cycle after the sampling edge, one cycle wide.
- **Init:** 2^AW cycles after reset release; the first non-retry response is possible at edge 2^AW.
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Configuration
- **`I2D_IMEM_WRITE_EN` defined:** writes are supported as described above.
- **`I2D_IMEM_WRITE_EN` undefined:**
  - any in-window, aligned request with `we_i`=1 and `init_done`=1 gets `err_o` one cycle after sampling.
  - the array is not modified; the write port exists only for the init clear.
  - reads are unchanged.

## Test plan
All scenarios use AW=4, WAIT=2, BASE=0 unless stated.
- **Retry then NOP read:** read 0x0 at cycle 3 after reset → `rty_o` in cycle 4. Read 0x8 at cycle 20 → `ack_o` 3 cycles later, `dat_o` = `{`I2D_INS_NOP,26'b0}`.
- **Byte-lane write:** write 0xDEADBEEF with sel 4'b1111 to 0x4, then 0x000000AA with sel 4'b0001 to 0x4, then read 0x4 → `dat_o` = 0xDEADBEAA.
- **Address errors:**
  - read 0x40 (outside window) → `err_o` one cycle, no ack, `dat_o` unchanged.
  - read 0x6 (misaligned) → `err_o`.
- **Abort:** write 0x12345678 to 0x8, drop `cyc_i` after one wait cycle → no ack. A subsequent read of 0x8 returns the NOP word.
- **Held strobe:** stb held over 3 reads → acks spaced exactly 4 cycles apart, never adjacent. Reset asserted mid-WAIT → no ack, and `rty_o` on the next request.
- **Macro undefined:** write 0xFFFFFFFF to 0xC → `err_o`; a read of 0xC returns the NOP word.
